// File: rtl/norm_share_pkg.sv
// norm_share_pkg
//   Shared configuration for the norm_share slice: default operand widths,
//   FSM state encodings and a small helper used by the arbiter.
//   Optional feature macro: NORM_SHARE_RR_EN (round-robin arbitration).
package norm_share_pkg;

  localparam int SIZE_MANTIS_DEF = 26;
  localparam int SIZE_EXP_DEF    = 8;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Requester index chosen when both are valid. last_id is the requester
  // granted on the previous handshake; rr selects round-robin behaviour.
  function automatic logic pick_on_tie(input logic last_id, input logic rr);
    return rr ? ~last_id : 1'b0;
  endfunction

endpackage

// File: rtl/norm_share_normalize.sv
// norm_share_normalize
//   Combinational normalizer. Shifts the mantissa left by its leading-zero
//   count, limited so the exponent never goes below zero.
// Ports:
//   mantis      in   SIZE_MANTIS  unnormalized mantissa
//   exp         in   SIZE_EXP     unnormalized exponent
//   norm_mantis out  SIZE_MANTIS  normalized mantissa
//   norm_exp    out  SIZE_EXP     normalized exponent
module norm_share_normalize
  import norm_share_pkg::*;
#(
  parameter int SIZE_MANTIS = SIZE_MANTIS_DEF,
  parameter int SIZE_EXP    = SIZE_EXP_DEF
) (
  input  logic [SIZE_MANTIS-1:0] mantis,
  input  logic [SIZE_EXP-1:0]    exp,
  output logic [SIZE_MANTIS-1:0] norm_mantis,
  output logic [SIZE_EXP-1:0]    norm_exp
);

  logic [31:0] lz;

  // Scan upward so the highest set bit determines the count; an all-zero
  // mantissa leaves lz at 0 and therefore passes through unchanged.
  always_comb begin
    lz = 32'd0;
    for (int i = 0; i < SIZE_MANTIS; i++) begin
      if (mantis[i]) lz = 32'(SIZE_MANTIS - 1 - i);
    end
  end

  always_comb begin
    norm_mantis = mantis;
    norm_exp    = exp;
    if (32'(exp) >= lz) begin
      norm_mantis = mantis << lz;
      norm_exp    = exp - SIZE_EXP'(lz);
    end else begin
      // Exponent underflow: shift only as far as the exponent allows.
      norm_mantis = mantis << exp;
      norm_exp    = '0;
    end
  end

endmodule

// File: rtl/norm_share.sv
// norm_share
//   Two requesters share one normalizer. An arbiter grants one operand,
//   the FSM (IDLE -> BUSY -> DONE) latches it, registers the normalized
//   result and holds it until the consumer takes it.
//   Optional feature macro: NORM_SHARE_RR_EN -- round-robin arbitration on
//   simultaneous requests; otherwise req0 has fixed priority.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req{0,1}_valid/ready        requester handshake (ready combinational)
//   req{0,1}_exp/mantis         requester operand
//   out_valid/out_ready         result handshake
//   out_exp/out_mantis/out_id   registered result and source requester
//
// state | meaning
// IDLE  | waiting for a requester; ready offered to the granted one
// BUSY  | operand latched; result registered on the next edge
// DONE  | result held; may accept a new operand in the take cycle
module norm_share
  import norm_share_pkg::*;
#(
  parameter int SIZE_MANTIS = SIZE_MANTIS_DEF,
  parameter int SIZE_EXP    = SIZE_EXP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [SIZE_EXP-1:0]    req0_exp,
  input  logic [SIZE_MANTIS-1:0] req0_mantis,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [SIZE_EXP-1:0]    req1_exp,
  input  logic [SIZE_MANTIS-1:0] req1_mantis,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE_EXP-1:0]    out_exp,
  output logic [SIZE_MANTIS-1:0] out_mantis,
  output logic                   out_id
);

  logic [1:0]             state;
  logic [SIZE_EXP-1:0]    lat_exp;
  logic [SIZE_MANTIS-1:0] lat_mantis;
  logic                   lat_id;
  logic [SIZE_EXP-1:0]    norm_exp;
  logic [SIZE_MANTIS-1:0] norm_mantis;
  logic                   can_take;
  logic                   grant0;
  logic                   grant1;
  logic                   tie_pick;
  logic                   hs;

`ifdef NORM_SHARE_RR_EN
  logic last_id;

  // Reset to 1 so the first tie goes to req0.
  always_ff @(posedge clk) begin
    if (rst)     last_id <= 1'b1;
    else if (hs) last_id <= grant1;
  end

  assign tie_pick = pick_on_tie(last_id, 1'b1);
`else
  assign tie_pick = pick_on_tie(1'b0, 1'b0);
`endif

  assign can_take = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = !tie_pick;
      grant1 = tie_pick;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = can_take && grant0;
  assign req1_ready = can_take && grant1;
  assign hs         = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_exp    <= '0;
      lat_mantis <= '0;
      lat_id     <= 1'b0;
    end else if (hs) begin
      lat_exp    <= grant1 ? req1_exp    : req0_exp;
      lat_mantis <= grant1 ? req1_mantis : req0_mantis;
      lat_id     <= grant1;
    end
  end

  norm_share_normalize #(
    .SIZE_MANTIS(SIZE_MANTIS),
    .SIZE_EXP   (SIZE_EXP)
  ) u_normalize (
    .mantis     (lat_mantis),
    .exp        (lat_exp),
    .norm_mantis(norm_mantis),
    .norm_exp   (norm_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_exp    <= '0;
      out_mantis <= '0;
      out_id     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) state <= ST_BUSY;
        end
        ST_BUSY: begin
          out_exp    <= norm_exp;
          out_mantis <= norm_mantis;
          out_id     <= lat_id;
          out_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= hs ? ST_BUSY : ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_share.sv
module tb_norm_share;

  localparam int W = 26;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [E-1:0] req0_exp, req1_exp;
  logic [W-1:0] req0_mantis, req1_mantis;
  logic         out_valid, out_ready;
  logic [E-1:0] out_exp;
  logic [W-1:0] out_mantis;
  logic         out_id;

  int n_cmp = 0;
  int n_bad = 0;

  // transaction-level reference state
  bit     m_pending;      // operand accepted, result not yet visible
  bit     m_out_valid;
  longint m_res_mantis;
  int     m_res_exp;
  bit     m_res_id;
  longint m_op_mantis;
  int     m_op_exp;
  bit     m_op_id;
  bit     m_last;         // requester granted on the previous handshake

`ifdef NORM_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  norm_share dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_exp   (req0_exp),
    .req0_mantis(req0_mantis),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_exp   (req1_exp),
    .req1_mantis(req1_mantis),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp),
    .out_mantis (out_mantis),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Normalization from first principles: double until the top bit is set.
  function automatic void ref_norm(input longint m, input int e,
                                   output longint rm, output int re);
    int     sh = 0;
    longint t  = m;
    if (t != 0)
      while (t < (longint'(1) << (W - 1))) begin
        t = t * 2;
        sh++;
      end
    if (e >= sh) begin
      rm = m * (longint'(1) << sh);
      re = e - sh;
    end else begin
      rm = m * (longint'(1) << e);
      re = 0;
    end
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the
  // reference model across the rising edge.
  task automatic step(input bit r,
                      input bit v0, input logic [E-1:0] e0, input logic [W-1:0] m0,
                      input bit v1, input logic [E-1:0] e1, input logic [W-1:0] m1,
                      input bit ordy);
    bit allowed;
    int g;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_exp = e0; req0_mantis = m0;
    req1_valid = v1; req1_exp = e1; req1_mantis = m1;
    out_ready = ordy;
    #1;
    allowed = !r && !m_pending && (!m_out_valid || ordy);
    g = -1;
    if (allowed) begin
      if (v0 && v1) g = (RR && m_last == 1'b0) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    check("req0_ready", 64'(req0_ready), 64'(g == 0));
    check("req1_ready", 64'(req1_ready), 64'(g == 1));
    check("out_valid",  64'(out_valid),  64'(m_out_valid));
    check("out_mantis", 64'(out_mantis), 64'(m_res_mantis));
    check("out_exp",    64'(out_exp),    64'(m_res_exp));
    check("out_id",     64'(out_id),     64'(m_res_id));
    @(posedge clk);
    if (r) begin
      m_pending = 0; m_out_valid = 0;
      m_res_mantis = 0; m_res_exp = 0; m_res_id = 0;
      m_last = 1'b1;
    end else begin
      if (m_out_valid && ordy) m_out_valid = 0;
      if (m_pending) begin
        ref_norm(m_op_mantis, m_op_exp, m_res_mantis, m_res_exp);
        m_res_id    = m_op_id;
        m_out_valid = 1;
        m_pending   = 0;
      end
      if (g >= 0) begin
        m_pending   = 1;
        m_op_id     = (g == 1);
        m_op_mantis = (g == 1) ? longint'(m1) : longint'(m0);
        m_op_exp    = (g == 1) ? int'(e1) : int'(e0);
        m_last      = (g == 1);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, '0, '0, 0, '0, '0, ordy);
  endtask

  // Fixed-value check sampled just after the rising edge.
  task automatic expect_out(input string tag, input bit v, input logic [E-1:0] e,
                            input logic [W-1:0] m, input bit id);
    #1;
    check({tag, ".valid"},  64'(out_valid),  64'(v));
    check({tag, ".mantis"}, 64'(out_mantis), 64'(m));
    check({tag, ".exp"},    64'(out_exp),    64'(e));
    check({tag, ".id"},     64'(out_id),     64'(id));
  endtask

  function automatic logic [W-1:0] rand_mantis();
    logic [31:0] raw;
    raw = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 15) == 0) raw = 32'd0;
    return raw[W-1:0];
  endfunction

  function automatic logic [E-1:0] rand_exp();
    logic [31:0] raw;
    raw = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
    return raw[E-1:0];
  endfunction

  initial begin
    bit ids[$];
    bit want_ids[4];

    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_exp = '0; req1_exp = '0; req0_mantis = '0; req1_mantis = '0;
    m_last = 1'b1;

    // reset with both requesters valid: readies must stay low
    step(1, 1, 8'd1, 26'h1, 1, 8'd1, 26'h1, 1);
    step(1, 1, 8'd1, 26'h1, 1, 8'd1, 26'h1, 1);
    expect_out("reset", 0, 8'd0, 26'h0, 0);

    // req0: leading zeros 2, enough exponent
    step(0, 1, 8'd10, 26'h0800000, 0, '0, '0, 0);
    expect_out("lat1", 0, 8'd0, 26'h0, 0);
    idle(0);
    expect_out("r0_norm", 1, 8'd8, 26'h2000000, 0);
    idle(1);

    // req1: exponent too small, shift limited to the exponent
    step(0, 0, '0, '0, 1, 8'd3, 26'h0000001, 0);
    idle(0);
    expect_out("r1_uflow", 1, 8'd0, 26'h0000008, 1);
    idle(1);

    // zero mantissa passes through
    step(0, 1, 8'd5, 26'h0, 0, '0, '0, 0);
    idle(0);
    expect_out("zero", 1, 8'd5, 26'h0, 0);
    idle(1);

    // exponent exactly equals shift; MSB already set
    step(0, 0, '0, '0, 1, 8'd4, 26'h0200000, 0);
    idle(0);
    expect_out("eq_shift", 1, 8'd0, 26'h2000000, 1);
    idle(1);
    step(0, 1, 8'd7, 26'h3000000, 0, '0, '0, 0);
    idle(0);
    expect_out("msb_set", 1, 8'd7, 26'h3000000, 0);
    idle(1);

    // both valid continuously, consumer always ready, from a fresh reset
    step(1, 0, '0, '0, 0, '0, '0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'd9, 26'h0100000, 1, 8'd9, 26'h0100000, 1);
      #1;
      if (out_valid) ids.push_back(out_id);
    end
    check("seq.count", 64'(ids.size()), 64'd4);
    want_ids = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    for (int i = 0; i < 4 && i < ids.size(); i++)
      check($sformatf("seq.id%0d", i), 64'(ids[i]), 64'(want_ids[i]));
    idle(1);
    idle(1);

    // back-pressure for 5 cycles, then same-cycle accept of req1
    step(0, 1, 8'd2, 26'h0000100, 0, '0, '0, 0);
    idle(0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 8'd6, 26'h0000003, 1, 8'd6, 26'h0000003, 0);
    expect_out("hold", 1, 8'd0, 26'h0000400, 0);
    step(0, 0, '0, '0, 1, 8'd30, 26'h0000003, 1);
    idle(0);
    expect_out("after_hold", 1, 8'd6, 26'h3000000, 1);
    idle(1);

    // reset while BUSY drops the operand
    step(0, 1, 8'd12, 26'h0000F00, 0, '0, '0, 0);
    step(1, 0, '0, '0, 0, '0, '0, 1);
    expect_out("rst_busy", 0, 8'd0, 26'h0, 0);
    idle(1);
    expect_out("rst_drop", 0, 8'd0, 26'h0, 0);
    step(0, 0, '0, '0, 1, 8'd1, 26'h0000002, 0);
    idle(0);
    expect_out("post_rst", 1, 8'd0, 26'h0000004, 1);
    idle(1);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) != 0, rand_exp(), rand_mantis(),
           $urandom_range(0, 2) != 0, rand_exp(), rand_mantis(),
           $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
